// File: rtl/decode_idex_stage.sv
// decode_idex_stage: register file with write-through bypass, ID/EX register and load-use bubble insertion
module decode_idex_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       INSTR_D_i,
    input  logic              VALID_D_i,
    input  logic [XLEN-1:0]   PC_D_i,
    input  logic [XLEN-1:0]   PCPLUS4_D_i,
    input  logic [XLEN-1:0]   IMM_D_i,
    input  logic [CTRL_W-1:0] CTRL_D_i,
    input  logic              REGWRT_D_i,
    input  logic              MEMRD_D_i,
    input  logic              STALL_H_i,
    input  logic              FLUSH_H_i,
    input  logic              REG_WRT_W_i,
    input  logic [REG_AW-1:0] RESLT_ADDR_W_i,
    input  logic [XLEN-1:0]   RESLT_DATA_W_i,
    output logic              VALID_E_o,
    output logic              REGWRT_E_o,
    output logic              MEMRD_E_o,
    output logic [CTRL_W-1:0] CTRL_E_o,
    output logic [XLEN-1:0]   RD1_E_o,
    output logic [XLEN-1:0]   RD2_E_o,
    output logic [REG_AW-1:0] RS1_E_o,
    output logic [REG_AW-1:0] RS2_E_o,
    output logic [REG_AW-1:0] RD_E_o,
    output logic [XLEN-1:0]   PC_E_o,
    output logic [XLEN-1:0]   PCPLUS4_E_o,
    output logic [XLEN-1:0]   IMM_E_o,
    output logic [REG_AW-1:0] RS1_H_o,
    output logic [REG_AW-1:0] RS2_H_o,
    output logic              LOAD_USE_H_o
);
    logic [XLEN-1:0]   rf [NREG];
    logic [REG_AW-1:0] rd_d;
    logic [XLEN-1:0]   rd1_d, rd2_d;
    logic              wb_hit, bubble;

    assign RS1_H_o = INSTR_D_i[15 +: REG_AW];
    assign RS2_H_o = INSTR_D_i[20 +: REG_AW];
    assign rd_d    = INSTR_D_i[7 +: REG_AW];
    assign wb_hit  = REG_WRT_W_i && (RESLT_ADDR_W_i != '0);

    function automatic logic [XLEN-1:0] rf_read(input logic [REG_AW-1:0] a);
        if (a == '0 || int'(a) >= NREG) return '0;
        if (wb_hit && a == RESLT_ADDR_W_i) return RESLT_DATA_W_i;
        return rf[a];
    endfunction

    assign rd1_d = rf_read(RS1_H_o);
    assign rd2_d = rf_read(RS2_H_o);

    assign LOAD_USE_H_o = VALID_E_o && MEMRD_E_o && (RD_E_o != '0) && VALID_D_i &&
                          (RS1_H_o == RD_E_o || RS2_H_o == RD_E_o);
    // stall outranks load-use so a held load is not replaced by its own bubble
    assign bubble = FLUSH_H_i || (!STALL_H_i && (LOAD_USE_H_o || !VALID_D_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_hit && int'(RESLT_ADDR_W_i) < NREG) begin
            rf[RESLT_ADDR_W_i] <= RESLT_DATA_W_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bubble) begin
            VALID_E_o   <= 1'b0;
            REGWRT_E_o  <= 1'b0;
            MEMRD_E_o   <= 1'b0;
            CTRL_E_o    <= '0;
            RD1_E_o     <= '0;
            RD2_E_o     <= '0;
            RS1_E_o     <= '0;
            RS2_E_o     <= '0;
            RD_E_o      <= '0;
            PC_E_o      <= '0;
            PCPLUS4_E_o <= '0;
            IMM_E_o     <= '0;
        end else if (STALL_H_i) begin
            if (VALID_E_o && wb_hit && RESLT_ADDR_W_i == RS1_E_o) RD1_E_o <= RESLT_DATA_W_i;
            if (VALID_E_o && wb_hit && RESLT_ADDR_W_i == RS2_E_o) RD2_E_o <= RESLT_DATA_W_i;
        end else begin
            VALID_E_o   <= 1'b1;
            REGWRT_E_o  <= REGWRT_D_i;
            MEMRD_E_o   <= MEMRD_D_i;
            CTRL_E_o    <= CTRL_D_i;
            RD1_E_o     <= rd1_d;
            RD2_E_o     <= rd2_d;
            RS1_E_o     <= RS1_H_o;
            RS2_E_o     <= RS2_H_o;
            RD_E_o      <= rd_d;
            PC_E_o      <= PC_D_i;
            PCPLUS4_E_o <= PCPLUS4_D_i;
            IMM_E_o     <= IMM_D_i;
        end
    end
endmodule

// File: tb/tb_decode_idex_stage.sv
// tb_decode_idex_stage: directed checks of reset, bypass, load-use, stall refresh and priorities
module tb_decode_idex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] INSTR_D_i;
    logic        VALID_D_i;
    logic [31:0] PC_D_i, PCPLUS4_D_i, IMM_D_i;
    logic [15:0] CTRL_D_i;
    logic        REGWRT_D_i, MEMRD_D_i, STALL_H_i, FLUSH_H_i, REG_WRT_W_i;
    logic [4:0]  RESLT_ADDR_W_i;
    logic [31:0] RESLT_DATA_W_i;
    logic        VALID_E_o, REGWRT_E_o, MEMRD_E_o, LOAD_USE_H_o;
    logic [15:0] CTRL_E_o;
    logic [31:0] RD1_E_o, RD2_E_o, PC_E_o, PCPLUS4_E_o, IMM_E_o;
    logic [4:0]  RS1_E_o, RS2_E_o, RD_E_o, RS1_H_o, RS2_H_o;
    int errs = 0;
    int checks = 0;

    decode_idex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .INSTR_D_i(INSTR_D_i), .VALID_D_i(VALID_D_i),
        .PC_D_i(PC_D_i), .PCPLUS4_D_i(PCPLUS4_D_i), .IMM_D_i(IMM_D_i), .CTRL_D_i(CTRL_D_i),
        .REGWRT_D_i(REGWRT_D_i), .MEMRD_D_i(MEMRD_D_i), .STALL_H_i(STALL_H_i), .FLUSH_H_i(FLUSH_H_i),
        .REG_WRT_W_i(REG_WRT_W_i), .RESLT_ADDR_W_i(RESLT_ADDR_W_i), .RESLT_DATA_W_i(RESLT_DATA_W_i),
        .VALID_E_o(VALID_E_o), .REGWRT_E_o(REGWRT_E_o), .MEMRD_E_o(MEMRD_E_o), .CTRL_E_o(CTRL_E_o),
        .RD1_E_o(RD1_E_o), .RD2_E_o(RD2_E_o), .RS1_E_o(RS1_E_o), .RS2_E_o(RS2_E_o), .RD_E_o(RD_E_o),
        .PC_E_o(PC_E_o), .PCPLUS4_E_o(PCPLUS4_E_o), .IMM_E_o(IMM_E_o),
        .RS1_H_o(RS1_H_o), .RS2_H_o(RS2_H_o), .LOAD_USE_H_o(LOAD_USE_H_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [15:0] ctrl, input logic ld);
        INSTR_D_i   = {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
        VALID_D_i   = 1'b1;
        PC_D_i      = pc;
        PCPLUS4_D_i = pc + 32'd4;
        IMM_D_i     = pc ^ 32'h0000_0F0F;
        CTRL_D_i    = ctrl;
        REGWRT_D_i  = 1'b1;
        MEMRD_D_i   = ld;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        REG_WRT_W_i    = en;
        RESLT_ADDR_W_i = a;
        RESLT_DATA_W_i = d;
    endtask

    initial begin
        rst_i = 1'b1; STALL_H_i = 1'b0; FLUSH_H_i = 1'b0;
        dec(0, 0, 0, 0, 0, 0); VALID_D_i = 1'b0; REGWRT_D_i = 1'b0;
        wb(0, 0, 0);
        tick();
        rst_i = 1'b0;
        chk("rst_valid", VALID_E_o, 0);
        chk("rst_pc", PC_E_o, 0);
        // x5 written, then reset must clear it even though the rf held 0x11
        wb(1, 5, 32'h11);
        tick();
        wb(0, 0, 0); rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst2_ctrl", CTRL_E_o, 0);
        chk("rst2_rd1", RD1_E_o, 0);
        dec(5, 0, 1, 32'h100, 16'h00F1, 0);
        tick();
        chk("rf_cleared_valid", VALID_E_o, 1);
        chk("rf_cleared_rd1", RD1_E_o, 0);
        chk("rf_cleared_rs1", RS1_E_o, 5);
        chk("load_pc4", PCPLUS4_E_o, 32'h104);
        chk("load_imm", IMM_E_o, 32'h0000_0E0F);
        // write-through bypass
        wb(1, 5, 32'hDEADBEEF);
        dec(5, 0, 1, 32'h104, 16'h00F2, 0);
        tick();
        chk("bypass_rd1", RD1_E_o, 32'hDEADBEEF);
        wb(1, 0, 32'h1234);
        dec(5, 0, 2, 32'h108, 16'h00F3, 0);
        tick();
        chk("x0_bypass_rd2", RD2_E_o, 0);
        chk("x5_stored_rd1", RD1_E_o, 32'hDEADBEEF);
        wb(0, 0, 0);
        dec(0, 0, 3, 32'h10C, 16'h00F4, 0);
        tick();
        chk("x0_read", RD1_E_o, 0);
        VALID_D_i = 1'b0;
        tick();
        chk("invalid_bubble_valid", VALID_E_o, 0);
        chk("invalid_bubble_pc", PC_E_o, 0);
        // load-use: lw x7 then add x8,x7,x1
        dec(5, 0, 7, 32'h200, 16'h0A0A, 1);
        tick();
        chk("lw_memrd", MEMRD_E_o, 1);
        chk("lw_rd", RD_E_o, 7);
        dec(7, 1, 8, 32'h204, 16'h0B0B, 0);
        #1;
        chk("lu_rs1_h", RS1_H_o, 7);
        chk("lu_hazard", LOAD_USE_H_o, 1);
        tick();
        chk("lu_bubble_valid", VALID_E_o, 0);
        chk("lu_bubble_regwrt", REGWRT_E_o, 0);
        chk("lu_bubble_ctrl", CTRL_E_o, 0);
        chk("lu_clear", LOAD_USE_H_o, 0);
        tick();
        chk("lu_issue_valid", VALID_E_o, 1);
        chk("lu_issue_rs1", RS1_E_o, 7);
        chk("lu_issue_rd", RD_E_o, 8);
        // load from x0 never raises a hazard
        dec(0, 0, 0, 32'h208, 16'h0C0C, 1);
        tick();
        dec(0, 0, 9, 32'h20C, 16'h0C0D, 0);
        #1;
        chk("lu_x0_none", LOAD_USE_H_o, 0);
        // stall refresh of held operands
        dec(5, 3, 9, 32'h300, 16'h1234, 0);
        tick();
        chk("pre_stall_rd1", RD1_E_o, 32'hDEADBEEF);
        chk("pre_stall_rd2", RD2_E_o, 0);
        STALL_H_i = 1'b1;
        dec(1, 2, 4, 32'h400, 16'h4444, 0);
        wb(1, 3, 32'h55);
        tick();
        chk("refresh_rd2", RD2_E_o, 32'h55);
        chk("refresh_pc", PC_E_o, 32'h300);
        chk("refresh_ctrl", CTRL_E_o, 16'h1234);
        chk("refresh_rd1", RD1_E_o, 32'hDEADBEEF);
        wb(0, 0, 0);
        tick();
        chk("stall2_rd2", RD2_E_o, 32'h55);
        chk("stall2_rs2", RS2_E_o, 3);
        wb(1, 5, 32'h77);
        tick();
        chk("refresh_rd1_b", RD1_E_o, 32'h77);
        chk("refresh_rd2_hold", RD2_E_o, 32'h55);
        wb(0, 0, 0);
        // stall beats load-use
        STALL_H_i = 1'b0;
        dec(5, 0, 7, 32'h500, 16'h5555, 1);
        tick();
        STALL_H_i = 1'b1;
        dec(7, 0, 10, 32'h504, 16'h6666, 0);
        #1;
        chk("stall_lu_hazard", LOAD_USE_H_o, 1);
        tick();
        chk("stall_lu_valid", VALID_E_o, 1);
        chk("stall_lu_memrd", MEMRD_E_o, 1);
        chk("stall_lu_pc", PC_E_o, 32'h500);
        // flush beats stall
        FLUSH_H_i = 1'b1;
        tick();
        FLUSH_H_i = 1'b0;
        chk("flush_valid", VALID_E_o, 0);
        chk("flush_ctrl", CTRL_E_o, 0);
        chk("flush_pc", PC_E_o, 0);
        // reset mid-stall
        STALL_H_i = 1'b0;
        dec(1, 2, 11, 32'h600, 16'h7777, 0);
        tick();
        chk("pre_rst_valid", VALID_E_o, 1);
        STALL_H_i = 1'b1; rst_i = 1'b1;
        wb(1, 5, 32'h99);
        tick();
        chk("rst_stall_valid", VALID_E_o, 0);
        chk("rst_stall_pc", PC_E_o, 0);
        chk("rst_stall_ctrl", CTRL_E_o, 0);
        rst_i = 1'b0; STALL_H_i = 1'b0;
        wb(0, 0, 0);
        dec(5, 0, 12, 32'h700, 16'h8888, 0);
        tick();
        chk("post_rst_valid", VALID_E_o, 1);
        chk("post_rst_pc", PC_E_o, 32'h700);
        chk("post_rst_rd1", RD1_E_o, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
